// File: rtl/mem_2r1w_sync_gated_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_2r1w_sync_gated_pkg: sizing helpers for the 2R1W memory. rev 1.0 |
// +--------------------------------------------------------------------+
package mem_2r1w_sync_gated_pkg;

  // Never returns 0 so a single-word memory still gets a 1-bit address.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_2r1w_sync_gated_clkgate_latch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clkgate_latch: low-transparent latch clock gate. rev 1.0            |
// +--------------------------------------------------------------------+
module clkgate_latch (
  input  logic clk_i,
  input  logic en_i,
  input  logic bypass_i,
  output logic gated_clock_o
);

  logic en_latched;

  // Enable only moves while clk_i is low, so the AND below cannot glitch.
  always_latch begin
    if (!clk_i) en_latched <= en_i | bypass_i;
  end

  assign gated_clock_o = clk_i & en_latched;

endmodule
`default_nettype wire

// File: rtl/mem_2r1w_sync_gated.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_2r1w_sync_gated: 2-read/1-write synchronous RAM, registered     |
// | reads, optional clock gate in front of the array. rev 1.0          |
// +--------------------------------------------------------------------+
module mem_2r1w_sync_gated
  import mem_2r1w_sync_gated_pkg::*;
#(
  parameter int width_p                = 32,
  parameter int els_p                  = 32,
  parameter int read_write_same_addr_p = 0,
  parameter int enable_clock_gating_p  = 0,
  localparam int addr_width_lp         = safe_clog2(els_p),
  localparam int data_width_lp         = max1(width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [data_width_lp-1:0] w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  output logic [data_width_lp-1:0] r0_data_o,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [data_width_lp-1:0] r1_data_o
);

  logic array_clk;

  generate
    if (enable_clock_gating_p != 0) begin : g_clkgate
      logic clk_en;
      // Reset is folded into the enable so the output clear is never gated off.
      assign clk_en = w_v_i | r0_v_i | r1_v_i | ~reset_i;
      clkgate_latch u_clkgate (
        .clk_i        (clk_i),
        .en_i         (clk_en),
        .bypass_i     (1'b0),
        .gated_clock_o(array_clk)
      );
    end else begin : g_no_clkgate
      assign array_clk = clk_i;
    end
  endgenerate

  generate
    if (width_p == 0) begin : g_no_storage
      logic unused_inputs;
      assign unused_inputs = ^{array_clk, reset_i, w_v_i, w_addr_i, w_data_i,
                               r0_v_i, r0_addr_i, r1_v_i, r1_addr_i};
      assign r0_data_o = '0;
      assign r1_data_o = '0;
    end else begin : g_storage
      localparam logic [addr_width_lp:0] c_els = (addr_width_lp + 1)'(els_p);
      localparam logic                   c_bypass = (read_write_same_addr_p != 0);

      logic [data_width_lp-1:0] mem_q [els_p];
      logic [data_width_lp-1:0] r0_data_d, r0_data_q;
      logic [data_width_lp-1:0] r1_data_d, r1_data_q;
      logic w_ok, r0_ok, r1_ok, r0_hit, r1_hit;

      always_comb begin
        w_ok   = {1'b0, w_addr_i}  < c_els;
        r0_ok  = {1'b0, r0_addr_i} < c_els;
        r1_ok  = {1'b0, r1_addr_i} < c_els;
        r0_hit = c_bypass & w_v_i & (w_addr_i == r0_addr_i);
        r1_hit = c_bypass & w_v_i & (w_addr_i == r1_addr_i);

        r0_data_d = r0_data_q;
        if (r0_v_i) begin
          if (!r0_ok)      r0_data_d = '0;
          else if (r0_hit) r0_data_d = w_data_i;
          else             r0_data_d = mem_q[r0_addr_i];
        end

        r1_data_d = r1_data_q;
        if (r1_v_i) begin
          if (!r1_ok)      r1_data_d = '0;
          else if (r1_hit) r1_data_d = w_data_i;
          else             r1_data_d = mem_q[r1_addr_i];
        end
      end

      always_ff @(posedge array_clk) begin
        if (!reset_i) begin
          r0_data_q <= '0;
          r1_data_q <= '0;
        end else begin
          r0_data_q <= r0_data_d;
          r1_data_q <= r1_data_d;
        end
      end

      // Array contents survive reset; only the write is suppressed.
      always_ff @(posedge array_clk) begin
        if (reset_i && w_v_i && w_ok) mem_q[w_addr_i] <= w_data_i;
      end

      assign r0_data_o = r0_data_q;
      assign r1_data_o = r1_data_q;

`ifndef BSG_HIDE_FROM_SYNTHESIS
      always @(negedge clk_i) begin
        if (reset_i && w_v_i && !w_ok)
          $display("%m: error: write address %0d out of range", w_addr_i);
        if (!c_bypass && reset_i && w_v_i && r0_v_i && (w_addr_i == r0_addr_i))
          $display("%m: error: port 0 read/write collision at address %0d", w_addr_i);
        if (!c_bypass && reset_i && w_v_i && r1_v_i && (w_addr_i == r1_addr_i))
          $display("%m: error: port 1 read/write collision at address %0d", w_addr_i);
      end
`endif
    end
  endgenerate

`ifndef BSG_HIDE_FROM_SYNTHESIS
  initial begin
    $display("%m: width_p=%0d els_p=%0d read_write_same_addr_p=%0d enable_clock_gating_p=%0d",
             width_p, els_p, read_write_same_addr_p, enable_clock_gating_p);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_2r1w_sync_gated.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_2r1w_sync_gated: scoreboard bench, two configurations. rev 1.0 |
// +--------------------------------------------------------------------+
module tb_mem_2r1w_sync_gated;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        w_v_i, r0_v_i, r1_v_i;
  logic [4:0]  w_addr_i, r0_addr_i, r1_addr_i;
  logic [31:0] w_data_i;
  logic [31:0] a_r0, a_r1, b_r0, b_r1;

  always #5 clk = ~clk;

  // Instance a: bypass on, gated, 20 words. Instance b: no bypass, ungated, 32 words.
  mem_2r1w_sync_gated #(.width_p(32), .els_p(20), .read_write_same_addr_p(1),
                        .enable_clock_gating_p(1)) u_a (
    .clk_i(clk), .reset_i(reset_i), .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .r0_v_i(r0_v_i), .r0_addr_i(r0_addr_i), .r0_data_o(a_r0),
    .r1_v_i(r1_v_i), .r1_addr_i(r1_addr_i), .r1_data_o(a_r1));

  mem_2r1w_sync_gated #(.width_p(32), .els_p(32), .read_write_same_addr_p(0),
                        .enable_clock_gating_p(0)) u_b (
    .clk_i(clk), .reset_i(reset_i), .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .r0_v_i(r0_v_i), .r0_addr_i(r0_addr_i), .r0_data_o(b_r0),
    .r1_v_i(r1_v_i), .r1_addr_i(r1_addr_i), .r1_data_o(b_r1));

  typedef struct {
    int          due;
    int          inst;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int edge_cnt  = 0;
  int gclk_cnt  = 0;
  int n_checks  = 0;
  int n_errors  = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge u_a.array_clk) gclk_cnt <= gclk_cnt + 1;

  task automatic push(input int inst, input int port, input logic [31:0] e, input string nm);
    exp_t t;
    t.due  = edge_cnt + 1;
    t.inst = inst;
    t.port = port;
    t.exp  = e;
    t.name = nm;
    sb.push_back(t);
  endtask

  task automatic step(input logic rst, input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic r0v, input logic [4:0] r0a, input logic r1v, input logic [4:0] r1a,
                      input logic [31:0] ea0, input logic [31:0] ea1,
                      input logic [31:0] eb0, input logic [31:0] eb1, input string nm);
    reset_i   = rst;
    w_v_i     = wv;  w_addr_i  = wa;  w_data_i = wd;
    r0_v_i    = r0v; r0_addr_i = r0a;
    r1_v_i    = r1v; r1_addr_i = r1a;
    push(0, 0, ea0, nm); push(0, 1, ea1, nm);
    push(1, 0, eb0, nm); push(1, 1, eb1, nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output is due right after the edge it was pushed for.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case ({e.inst[0], e.port[0]})
          2'b00:   act = a_r0;
          2'b01:   act = a_r1;
          2'b10:   act = b_r0;
          default: act = b_r1;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s inst=%s r%0d_data_o: got %h expected %h",
                   e.name, (e.inst == 0) ? "a" : "b", e.port, act, e.exp);
        end
      end
    end
  end

  initial begin
    int g0;
    step(0, 1, 5,  32'h00000BAD, 1, 5, 1, 5, 0, 0, 0, 0, "reset1");
    step(0, 1, 5,  32'h00000BAD, 1, 5, 1, 5, 0, 0, 0, 0, "reset2");
    step(1, 1, 7,  32'h00000077, 0, 0, 0, 0, 0, 0, 0, 0, "wr7");
    step(0, 1, 7,  32'h00000BAD, 1, 7, 0, 0, 0, 0, 0, 0, "reset_blocks_write");
    step(1, 1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, "wr5");
    step(1, 0, 0,  32'h0,        1, 5, 1, 5,
         32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "rd5_both_ports");
    step(1, 1, 5,  32'h00000001, 0, 0, 1, 7,
         32'hDEADBEEF, 32'h77, 32'hDEADBEEF, 32'h77, "r0_hold_rd7");
    step(1, 1, 3,  32'h00000011, 0, 0, 0, 0,
         32'hDEADBEEF, 32'h77, 32'hDEADBEEF, 32'h77, "wr3_old");
    step(1, 1, 3,  32'hA5A5A5A5, 1, 3, 0, 0,
         32'hA5A5A5A5, 32'h77, 32'h00000011, 32'h77, "collision");
    step(1, 0, 0,  32'h0,        1, 3, 1, 5,
         32'hA5A5A5A5, 32'h1, 32'hA5A5A5A5, 32'h1, "rd3_rd5");
    step(1, 1, 25, 32'hCAFEF00D, 0, 0, 0, 0,
         32'hA5A5A5A5, 32'h1, 32'hA5A5A5A5, 32'h1, "wr25");
    step(1, 0, 0,  32'h0,        1, 25, 1, 25,
         32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, "rd25");
    g0 = gclk_cnt;
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, "idle_hold");
    n_checks++;
    if (gclk_cnt != g0) begin
      n_errors++;
      $display("FAIL gated_clock_idle: got %0d edges expected 0", gclk_cnt - g0);
    end
    step(1, 0, 0,  32'h0,        0, 0, 1, 3,
         32'h0, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5, "wake_r1");
    n_checks++;
    if (gclk_cnt != g0 + 1) begin
      n_errors++;
      $display("FAIL gated_clock_wake: got %0d edges expected 1", gclk_cnt - g0);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
